// File: rtl/mddr_arbiter.sv
// Two-port Avalon-MM arbiter in front of the mDDR controller: round-robin grant,
// write-burst lock and an in-order read-return tracker that steers readdatavalid.
module mddr_arbiter #(
   parameter int unsigned AW          = 24,
   parameter int unsigned DW          = 32,
   parameter int unsigned BCW         = 4,
   parameter int unsigned OUTSTANDING = 8
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,

   input  logic [AW-1:0]     m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DW-1:0]     m0_writedata,
   input  logic [DW/8-1:0]   m0_byteenable,
   input  logic [BCW-1:0]    m0_burstcount,
   output logic              m0_waitrequest,
   output logic [DW-1:0]     m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [AW-1:0]     m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DW-1:0]     m1_writedata,
   input  logic [DW/8-1:0]   m1_byteenable,
   input  logic [BCW-1:0]    m1_burstcount,
   output logic              m1_waitrequest,
   output logic [DW-1:0]     m1_readdata,
   output logic              m1_readdatavalid,

   output logic [AW-1:0]     s_address,
   output logic              s_read,
   output logic              s_write,
   output logic [DW-1:0]     s_writedata,
   output logic [DW/8-1:0]   s_byteenable,
   output logic [BCW-1:0]    s_burstcount,
   input  logic              s_waitrequest,
   input  logic [DW-1:0]     s_readdata,
   input  logic              s_readdatavalid,

   output logic              err_o
);

   localparam int unsigned PW = $clog2(OUTSTANDING);

   typedef enum logic [1:0] {StIdle, StGrant0, StGrant1, StWburst} state_e;

   state_e           state_q;
   logic             owner_q;
   logic             last_grant_q;
   logic [BCW-1:0]   wcnt_q;
   logic [BCW-1:0]   rcnt_q;
   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    rptr_q;
   logic [PW:0]      count_q;
   logic             err_q;
   logic [BCW:0]     fifo_mem [OUTSTANDING];

   logic             req0, req1, pick;
   logic             sel_read, sel_write;
   logic [BCW-1:0]   sel_bc;
   logic             granted, in_grant;
   logic             fifo_full, fifo_empty;
   logic             port_wait;
   logic             push, pop, wr_acc, beat;
   logic [BCW:0]     head;
   logic [BCW-1:0]   rem;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;
   // On a tie the port that did not win last time goes next.
   assign pick = (req0 & req1) ? ~last_grant_q : req1;

   assign sel_read  = owner_q ? m1_read       : m0_read;
   assign sel_write = owner_q ? m1_write      : m0_write;
   assign sel_bc    = owner_q ? m1_burstcount : m0_burstcount;

   assign granted    = (state_q != StIdle);
   assign in_grant   = (state_q == StGrant0) || (state_q == StGrant1);
   assign fifo_full  = (count_q == (PW+1)'(OUTSTANDING));
   assign fifo_empty = (count_q == '0);

   assign s_address    = owner_q ? m1_address    : m0_address;
   assign s_writedata  = owner_q ? m1_writedata  : m0_writedata;
   assign s_byteenable = owner_q ? m1_byteenable : m0_byteenable;
   assign s_burstcount = sel_bc;
   assign s_read       = in_grant & sel_read & ~fifo_full;
   assign s_write      = granted & sel_write;

   assign port_wait      = s_waitrequest | (sel_read & fifo_full);
   assign m0_waitrequest = (granted && !owner_q) ? port_wait : 1'b1;
   assign m1_waitrequest = (granted &&  owner_q) ? port_wait : 1'b1;

   assign push   = s_read & ~s_waitrequest;
   assign wr_acc = s_write & ~s_waitrequest;

   assign head = fifo_mem[rptr_q];
   assign beat = s_readdatavalid & ~fifo_empty;
   // rcnt_q == 0 means the head burst has not returned any beat yet.
   assign rem  = (rcnt_q == '0) ? head[BCW-1:0] : rcnt_q;
   assign pop  = beat & (rem <= BCW'(1));

   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = beat & ~head[BCW];
   assign m1_readdatavalid = beat &  head[BCW];
   assign err_o            = err_q;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         wcnt_q       <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req0 | req1) begin
                  state_q      <= pick ? StGrant1 : StGrant0;
                  owner_q      <= pick;
                  last_grant_q <= pick;
               end
            end
            StGrant0, StGrant1: begin
               if (push) begin
                  state_q <= StIdle;
               end else if (wr_acc) begin
                  if (sel_bc <= BCW'(1)) begin
                     state_q <= StIdle;
                  end else begin
                     wcnt_q  <= sel_bc - BCW'(1);
                     state_q <= StWburst;
                  end
               end else if (!(sel_read | sel_write)) begin
                  state_q <= StIdle;
               end
            end
            StWburst: begin
               if (wr_acc) begin
                  if (wcnt_q <= BCW'(1)) begin
                     state_q <= StIdle;
                  end
                  wcnt_q <= wcnt_q - BCW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         rcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + PW'(1);
         if (pop)  rptr_q <= rptr_q + PW'(1);
         if (push && !pop) count_q <= count_q + (PW+1)'(1);
         else if (!push && pop) count_q <= count_q - (PW+1)'(1);
         if (beat) rcnt_q <= pop ? '0 : rem - BCW'(1);
         if (s_readdatavalid && fifo_empty) err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (push) fifo_mem[wptr_q] <= {owner_q, sel_bc};
   end

endmodule

// File: tb/tb_mddr_arbiter.sv
// Directed bench for mddr_arbiter: inputs change on the falling edge and
// outputs are checked 1 ns later, with the bench playing the slave by hand.
module tb_mddr_arbiter;

   logic        clk_clk = 1'b0;
   logic        reset_reset_n = 1'b0;
   logic [23:0] m0_address, m1_address, s_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata, s_writedata;
   logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
   logic [3:0]  m0_burstcount, m1_burstcount, s_burstcount;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata, s_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        s_read, s_write, s_waitrequest, s_readdatavalid, err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_clk = ~clk_clk;

   mddr_arbiter dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_burstcount(m0_burstcount), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_burstcount(m1_burstcount), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_burstcount(s_burstcount), .s_waitrequest(s_waitrequest),
      .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .err_o(err_o)
   );

   task automatic cyc();
      @(negedge clk_clk);
   endtask

   task automatic idle_inputs();
      m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0;
      m0_byteenable = 4'hF; m0_burstcount = 4'd1;
      m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;
      m1_byteenable = 4'hF; m1_burstcount = 4'd1;
      s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
   endtask

   task automatic do_reset();
      cyc();
      reset_reset_n = 0;
      idle_inputs();
      cyc();
      reset_reset_n = 1;
   endtask

   task automatic test_reset();
      reset_reset_n = 0;
      idle_inputs();
      s_readdatavalid = 1;
      #1;
      checks++;
      if (m0_waitrequest !== 1 || m1_waitrequest !== 1 || s_read !== 0 || s_write !== 0 ||
          m0_readdatavalid !== 0 || m1_readdatavalid !== 0 || err_o !== 0) begin
         errors++;
         $display("FAIL reset_outputs: w0=%b w1=%b rd=%b wr=%b v0=%b v1=%b err=%b, want 1 1 0 0 0 0 0",
                  m0_waitrequest, m1_waitrequest, s_read, s_write, m0_readdatavalid,
                  m1_readdatavalid, err_o);
      end
      s_readdatavalid = 0;
      cyc();
      reset_reset_n = 1;
   endtask

   task automatic test_single_read();
      m0_read = 1; m0_address = 24'h000010; m0_burstcount = 1;
      #1;
      checks++;
      if (s_read !== 0 || m0_waitrequest !== 1) begin
         errors++;
         $display("FAIL single_idle: s_read=%b w0=%b, want 0 1", s_read, m0_waitrequest);
      end
      cyc(); #1;
      checks++;
      if (s_read !== 1 || s_address !== 24'h000010 || m0_waitrequest !== 0 || m1_waitrequest !== 1) begin
         errors++;
         $display("FAIL single_cmd: s_read=%b addr=%h w0=%b w1=%b, want 1 000010 0 1",
                  s_read, s_address, m0_waitrequest, m1_waitrequest);
      end
      cyc(); m0_read = 0;
      cyc(); cyc();
      s_readdatavalid = 1; s_readdata = 32'hDEADBEEF;
      #1;
      checks++;
      if (m0_readdatavalid !== 1 || m0_readdata !== 32'hDEADBEEF || m1_readdatavalid !== 0) begin
         errors++;
         $display("FAIL single_return: v0=%b d0=%h v1=%b, want 1 deadbeef 0",
                  m0_readdatavalid, m0_readdata, m1_readdatavalid);
      end
      cyc(); s_readdatavalid = 0; #1;
      checks++;
      if (m0_readdatavalid !== 0 || err_o !== 0) begin
         errors++;
         $display("FAIL single_after: v0=%b err=%b, want 0 0", m0_readdatavalid, err_o);
      end
   endtask

   task automatic test_tie();
      logic odd;
      logic [23:0] exp_addr;
      do_reset();
      m0_read = 1; m0_address = 24'h000100; m0_burstcount = 1;
      m1_read = 1; m1_address = 24'h000200; m1_burstcount = 1;
      for (int i = 0; i < 4; i++) begin
         odd = i[0];
         exp_addr = odd ? 24'h000200 : 24'h000100;
         #1;
         checks++;
         if (s_read !== 0 || m0_waitrequest !== 1 || m1_waitrequest !== 1) begin
            errors++;
            $display("FAIL tie_idle%0d: s_read=%b w0=%b w1=%b, want 0 1 1",
                     i, s_read, m0_waitrequest, m1_waitrequest);
         end
         cyc(); #1;
         checks++;
         if (s_read !== 1 || s_address !== exp_addr || m0_waitrequest !== odd ||
             m1_waitrequest !== !odd) begin
            errors++;
            $display("FAIL tie_grant%0d: s_read=%b addr=%h w0=%b w1=%b, want 1 %h %b %b",
                     i, s_read, s_address, m0_waitrequest, m1_waitrequest, exp_addr, odd, !odd);
         end
         cyc();
      end
      m0_read = 0; m1_read = 0;
      cyc();
      for (int i = 0; i < 4; i++) begin
         odd = i[0];
         s_readdatavalid = 1; s_readdata = 32'h1000 + i;
         #1;
         checks++;
         if (m0_readdatavalid !== !odd || m1_readdatavalid !== odd) begin
            errors++;
            $display("FAIL tie_return%0d: v0=%b v1=%b, want %b %b",
                     i, m0_readdatavalid, m1_readdatavalid, !odd, odd);
         end
         cyc();
      end
      s_readdatavalid = 0;
   endtask

   task automatic test_write_burst();
      // per cycle: {master write, slave wait, data index}
      logic       wr_v [6] = '{1, 1, 1, 0, 1, 1};
      logic       wt_v [6] = '{0, 1, 0, 0, 0, 0};
      int         dx_v [6] = '{0, 1, 1, 1, 2, 3};
      int         beats = 0;
      logic [31:0] exp_d;
      m1_write = 1; m1_address = 24'h000300; m1_burstcount = 4; m1_writedata = 32'hA0;
      #1;
      checks++;
      if (s_write !== 0 || m1_waitrequest !== 1) begin
         errors++;
         $display("FAIL burst_idle: s_write=%b w1=%b, want 0 1", s_write, m1_waitrequest);
      end
      cyc();
      m0_read = 1; m0_address = 24'h000040; m0_burstcount = 1;
      for (int i = 0; i < 6; i++) begin
         m1_write = wr_v[i]; s_waitrequest = wt_v[i];
         exp_d = 32'hA0 + dx_v[i];
         m1_writedata = exp_d;
         #1;
         checks++;
         if (s_write !== wr_v[i] || m0_waitrequest !== 1 || s_read !== 0 ||
             (wr_v[i] && (m1_waitrequest !== wt_v[i] || s_writedata !== exp_d ||
                          s_burstcount !== 4'd4))) begin
            errors++;
            $display("FAIL burst_cyc%0d: s_write=%b w0=%b w1=%b data=%h bc=%0d, want %b 1 %b %h 4",
                     i, s_write, m0_waitrequest, m1_waitrequest, s_writedata, s_burstcount,
                     wr_v[i], wt_v[i], exp_d);
         end
         if (s_write === 1 && s_waitrequest === 0) beats++;
         cyc();
      end
      m1_write = 0; s_waitrequest = 0;
      #1;
      checks++;
      if (beats !== 4 || m0_waitrequest !== 1 || s_read !== 0) begin
         errors++;
         $display("FAIL burst_beats: beats=%0d w0=%b s_read=%b, want 4 1 0",
                  beats, m0_waitrequest, s_read);
      end
      cyc(); #1;
      checks++;
      if (s_read !== 1 || s_address !== 24'h000040 || m0_waitrequest !== 0) begin
         errors++;
         $display("FAIL burst_next_m0: s_read=%b addr=%h w0=%b, want 1 000040 0",
                  s_read, s_address, m0_waitrequest);
      end
      cyc(); m0_read = 0;
      cyc(); s_readdatavalid = 1; #1;
      checks++;
      if (m0_readdatavalid !== 1 || m1_readdatavalid !== 0) begin
         errors++;
         $display("FAIL burst_m0_return: v0=%b v1=%b, want 1 0", m0_readdatavalid, m1_readdatavalid);
      end
      cyc(); s_readdatavalid = 0;
   endtask

   task automatic test_interleaved();
      logic exp0;
      m0_read = 1; m0_address = 24'h000400; m0_burstcount = 2;
      cyc();
      m1_read = 1; m1_address = 24'h000500; m1_burstcount = 3;
      #1;
      checks++;
      if (s_read !== 1 || s_address !== 24'h000400 || s_burstcount !== 4'd2 || m1_waitrequest !== 1) begin
         errors++;
         $display("FAIL inter_cmd0: s_read=%b addr=%h bc=%0d w1=%b, want 1 000400 2 1",
                  s_read, s_address, s_burstcount, m1_waitrequest);
      end
      cyc(); m0_read = 0;
      cyc(); #1;
      checks++;
      if (s_read !== 1 || s_address !== 24'h000500 || s_burstcount !== 4'd3 || m1_waitrequest !== 0) begin
         errors++;
         $display("FAIL inter_cmd1: s_read=%b addr=%h bc=%0d w1=%b, want 1 000500 3 0",
                  s_read, s_address, s_burstcount, m1_waitrequest);
      end
      cyc(); m1_read = 0;
      for (int i = 0; i < 5; i++) begin
         exp0 = (i < 2);
         s_readdatavalid = 1; s_readdata = 32'hB0 + i;
         #1;
         checks++;
         if (m0_readdatavalid !== exp0 || m1_readdatavalid !== !exp0 ||
             m1_readdata !== 32'hB0 + i) begin
            errors++;
            $display("FAIL inter_beat%0d: v0=%b v1=%b d=%h, want %b %b %h",
                     i, m0_readdatavalid, m1_readdatavalid, m1_readdata, exp0, !exp0, 32'hB0 + i);
         end
         cyc();
      end
      s_readdatavalid = 0;
   endtask

   task automatic test_error();
      s_readdatavalid = 1;
      #1;
      checks++;
      if (m0_readdatavalid !== 0 || m1_readdatavalid !== 0 || err_o !== 0) begin
         errors++;
         $display("FAIL err_stray: v0=%b v1=%b err=%b, want 0 0 0",
                  m0_readdatavalid, m1_readdatavalid, err_o);
      end
      cyc(); s_readdatavalid = 0; #1;
      checks++;
      if (err_o !== 1) begin
         errors++;
         $display("FAIL err_set: err=%b, want 1", err_o);
      end
      repeat (3) cyc();
      #1;
      checks++;
      if (err_o !== 1) begin
         errors++;
         $display("FAIL err_held: err=%b, want 1", err_o);
      end
   endtask

   task automatic test_full_fifo();
      int issued = 0;
      m0_read = 1; m0_address = 24'h000600; m0_burstcount = 2;
      for (int i = 0; i < 8; i++) begin
         cyc(); #1;
         if (s_read === 1) issued++;
         cyc();
      end
      checks++;
      if (issued !== 8) begin
         errors++;
         $display("FAIL full_issue: issued=%0d, want 8", issued);
      end
      cyc(); #1;
      checks++;
      if (s_read !== 0 || m0_waitrequest !== 1) begin
         errors++;
         $display("FAIL full_block: s_read=%b w0=%b, want 0 1", s_read, m0_waitrequest);
      end
      cyc(); s_readdatavalid = 1; #1;
      checks++;
      if (s_read !== 0 || m0_readdatavalid !== 1) begin
         errors++;
         $display("FAIL full_beat1: s_read=%b v0=%b, want 0 1", s_read, m0_readdatavalid);
      end
      cyc(); #1;
      checks++;
      if (s_read !== 0 || m0_waitrequest !== 1) begin
         errors++;
         $display("FAIL full_beat2: s_read=%b w0=%b, want 0 1", s_read, m0_waitrequest);
      end
      cyc(); s_readdatavalid = 0; #1;
      checks++;
      if (s_read !== 1 || m0_waitrequest !== 0) begin
         errors++;
         $display("FAIL full_release: s_read=%b w0=%b, want 1 0", s_read, m0_waitrequest);
      end
      cyc(); m0_read = 0;
      issued = 0;
      for (int i = 0; i < 16; i++) begin
         s_readdatavalid = 1; #1;
         if (m0_readdatavalid === 1) issued++;
         cyc();
      end
      s_readdatavalid = 0;
      checks++;
      if (issued !== 16) begin
         errors++;
         $display("FAIL full_drain: beats=%0d, want 16", issued);
      end
   endtask

   task automatic test_reset_in_burst();
      m1_write = 1; m1_address = 24'h000700; m1_burstcount = 4;
      cyc(); cyc(); #1;
      checks++;
      if (s_write !== 1 || m0_waitrequest !== 1 || err_o !== 1) begin
         errors++;
         $display("FAIL rst_pre: s_write=%b w0=%b err=%b, want 1 1 1", s_write, m0_waitrequest, err_o);
      end
      reset_reset_n = 0;
      #1;
      checks++;
      if (s_write !== 0 || s_read !== 0 || m0_waitrequest !== 1 || m1_waitrequest !== 1 ||
          err_o !== 0) begin
         errors++;
         $display("FAIL rst_async: s_write=%b s_read=%b w0=%b w1=%b err=%b, want 0 0 1 1 0",
                  s_write, s_read, m0_waitrequest, m1_waitrequest, err_o);
      end
      cyc(); m1_write = 0; reset_reset_n = 1;
      m0_read = 1; m0_address = 24'h000800; m0_burstcount = 1;
      cyc(); cyc(); m0_read = 0;
      #1 reset_reset_n = 0;
      #1 reset_reset_n = 1;
      cyc(); s_readdatavalid = 1; #1;
      checks++;
      if (m0_readdatavalid !== 0 || m1_readdatavalid !== 0) begin
         errors++;
         $display("FAIL rst_late_route: v0=%b v1=%b, want 0 0", m0_readdatavalid, m1_readdatavalid);
      end
      cyc(); s_readdatavalid = 0; #1;
      checks++;
      if (err_o !== 1) begin
         errors++;
         $display("FAIL rst_late_err: err=%b, want 1", err_o);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_tie();
      cyc();
      test_write_burst();
      cyc();
      test_interleaved();
      cyc();
      test_error();
      cyc();
      test_full_fifo();
      cyc();
      test_reset_in_burst();
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mddr_arbiter.md
Name: mddr_arbiter

Overview:
Two-port Avalon-MM arbiter that shares the single mDDR controller slave port between two masters. Port 0 is the Nios CPU data master; port 1 is the DMA/video master. It applies round-robin arbitration, locks the grant for the full length of a write burst, and tracks pipelined read bursts. Returned read data is routed to the master that issued the request. It sits inside the SOPC between the interconnect masters and mddr_ctrl_0.

Parameters:
AW, 24, word address width of masters and slave
DW, 32, data width (byteenable width = DW/8)
BCW, 4, burstcount width (max burst 2^(BCW-1) beats)
OUTSTANDING, 8, depth of read-tracking FIFO (power of 2)

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
mX_address  in  AW  master X address (X = 0, 1; same set per master)
mX_read  in  1  read request
mX_write  in  1  write request/beat
mX_writedata  in  DW  write data
mX_byteenable  in  DW/8  byte enables
mX_burstcount  in  BCW  burst length, 1..2^(BCW-1)
mX_waitrequest  out  1  stall to master X
mX_readdata  out  DW  read data (broadcast of s_readdata)
mX_readdatavalid  out  1  read beat for master X
s_address/s_read/s_write/s_writedata/s_byteenable/s_burstcount  out  as master  command to mddr_ctrl
s_waitrequest  in  1  slave stall
s_readdata  in  DW  slave read data
s_readdatavalid  in  1  slave read beat
err_o  out  1  sticky: readdatavalid with no outstanding read

Behaviour:
- Reset (async, reset_reset_n low): state=IDLE, last_grant=1 (port 0 wins first tie), beat counters=0, FIFO empty, err_o=0, s_read=s_write=0, both mX_waitrequest=1, mX_readdatavalid=0. Reset during a burst drops all outstanding reads; late s_readdatavalid after reset sets err_o.
- FSM states: IDLE, GRANT0, GRANT1, WBURST.
- IDLE: requests are mX_read|mX_write. One requester -> grant it. Both requesting -> grant the port != last_grant. Transition to GRANTx on the next edge; last_grant<=x. No command is issued in IDLE, so minimum request-to-slave latency is 1 cycle.
- GRANTx: s_* driven combinationally from master x. mX_waitrequest = s_waitrequest | (read & fifo_full); the other master's waitrequest=1. s_read is gated low while fifo_full.
  - Read accepted (s_read & !s_waitrequest): push {x, burstcount} to FIFO -> IDLE.
  - Write beat accepted: if burstcount==1 -> IDLE; else load wcnt=burstcount-1 -> WBURST.
  - Request dropped before acceptance -> IDLE.
- WBURST: grant stays on x regardless of the other port. Each accepted write beat decrements wcnt; the beat accepted at wcnt==1 -> IDLE. s_burstcount is passed through unchanged on every beat. Master write deasserted mid-burst: s_write=0, stay in WBURST (no timeout).
- Read return:
  - mX_readdata=s_readdata for both ports.
  - mX_readdatavalid = s_readdatavalid & !fifo_empty & head_id==X.
  - rcnt loads the head burstcount on the first beat and decrements per beat. The FIFO pops on the last beat.
  - Push and pop in the same cycle are allowed; count is unchanged.
- fifo_full = count==OUTSTANDING. A read cannot be issued while full. A write can be issued while full.
- s_readdatavalid with FIFO empty: no readdatavalid to either port; err_o<=1 until reset.
- Fairness: after a grant to x, the next tie goes to the other port, so neither port waits more than one transaction while requesting.

Test Plan:
- Single reads: m0 reads addr 0x000010 bc=1; slave returns 0xDEADBEEF 3 cycles later -> m0_readdatavalid for 1 cycle with m0_readdata=0xDEADBEEF; m1_readdatavalid stays 0.
- Tie: m0 and m1 both read bc=1 from reset -> grant order m0, m1, m0, m1 over 4 transactions; each command reaches the slave 1 cycle after IDLE.
- Write burst lock: m1 writes bc=4 with s_waitrequest high on beat 2, and m0 requests mid-burst -> exactly 4 s_write beats from m1, then m0 is granted; m0_waitrequest=1 throughout the burst.
- Interleaved returns: m0 read bc=2, m1 read bc=3, slave returns 5 beats back-to-back -> beats 1-2 flagged to m0, beats 3-5 to m1; FIFO empty afterwards.
- Full FIFO: 8 reads outstanding, 9th read request -> m0_waitrequest=1 and s_read=0. One burst completes -> the 9th read is issued the next cycle.
- Errors/reset: s_readdatavalid with nothing outstanding -> err_o=1 and held. Async reset mid-WBURST -> all outputs at reset values immediately; err_o=0.
